ro_trng_ctrl: RTL and testbench

Controller for an array of NUM_RO free-running ring-oscillator cells in the TRNG.
- Enables the oscillators and waits a warm-up period.
- Synchronises the asynchronous oscillator outputs, XOR-combines them and decimates the result into raw bits.
- Packs the bits into WORD_W-bit words and hands them downstream over a valid/ready handshake.
- Discards stuck words (all 0s or all 1s) as a basic health check.

---
 rtl/ro_trng_ctrl.sv | 136 +++++++++++++
 tb/tb_ro_trng_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_trng_ctrl.sv
// ro_trng_ctrl: runs a ring-oscillator array, turns its XOR-combined samples into words and drops stuck words
module ro_trng_ctrl #(
   parameter int NUM_RO        = 8,
   parameter int WARMUP_CYCLES = 256,
   parameter int SAMPLE_DIV    = 16,
   parameter int WORD_W        = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   output logic [NUM_RO-1:0] ro_en,
   input  logic [NUM_RO-1:0] ro_in,
   output logic [WORD_W-1:0] rnd_data,
   output logic              rnd_valid,
   input  logic              rnd_ready,
   output logic              busy,
   output logic              stuck_err
);
   localparam int WU_W  = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
   localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int BIT_W = $clog2(WORD_W);
   localparam logic [WU_W-1:0]  WU_LAST  = WU_W'(WARMUP_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

   typedef enum logic [2:0] {S_IDLE, S_WARMUP, S_SAMPLE, S_CHECK, S_HOLD} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [NUM_RO-1:0] r_sync1;
   logic [NUM_RO-1:0] r_sync2;
   logic [WU_W-1:0]   r_wu_cnt;
   logic [DIV_W-1:0]  r_div;
   logic [BIT_W-1:0]  r_bit_cnt;
   logic [WORD_W-1:0] r_shift;
   logic [WORD_W-1:0] r_data;
   logic              r_valid;
   logic              w_raw;
   logic              w_hs;
   logic              w_tick;
   logic              w_sample;
   logic              w_last_bit;
   logic              w_wu_done;
   logic              w_stuck;
   logic              w_abort;

   assign w_raw      = ^r_sync2;
   assign w_hs       = r_valid & rnd_ready;
   // The handshake cycle in HOLD already counts as the first divider cycle of the next word,
   // so a consumed word is followed by the next one exactly WORD_W*SAMPLE_DIV+1 cycles later.
   assign w_tick     = (r_state == S_SAMPLE) | ((r_state == S_HOLD) & w_hs);
   assign w_sample   = w_tick & (r_div == DIV_LAST);
   assign w_last_bit = w_sample & (r_bit_cnt == BIT_LAST);
   assign w_wu_done  = r_wu_cnt == WU_LAST;
   assign w_stuck    = (r_shift == '0) | (&r_shift);
   assign w_abort    = stop & (r_state != S_IDLE);
   assign rnd_data   = r_data;
   assign rnd_valid  = r_valid;

   // two-flop synchroniser for the asynchronous oscillator outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= ro_in;
         r_sync2 <= r_sync1;
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // next-state logic; stop overrides everything, including start in IDLE
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_WARMUP;
         S_WARMUP: if (w_wu_done) w_next = S_SAMPLE;
         S_SAMPLE: if (w_last_bit) w_next = S_CHECK;
         S_CHECK:  w_next = w_stuck ? S_SAMPLE : S_HOLD;
         S_HOLD:   if (w_hs) w_next = S_SAMPLE;
         default:  w_next = S_IDLE;
      endcase
      if (stop) w_next = S_IDLE;
   end

   // state-decoded outputs
   always_comb begin
      busy      = r_state != S_IDLE;
      ro_en     = {NUM_RO{r_state != S_IDLE}};
      stuck_err = (r_state == S_CHECK) & w_stuck & ~stop;
   end

   // warm-up counter, sample divider, bit counter and shift register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wu_cnt  <= '0;
         r_div     <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
      end else if (stop || r_state == S_IDLE) begin
         r_wu_cnt  <= '0;
         r_div     <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
      end else begin
         r_wu_cnt <= (r_state == S_WARMUP && !w_wu_done) ? r_wu_cnt + 1'b1 : '0;
         if (w_tick) r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
         if (w_sample) begin
            r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
            r_shift   <= {r_shift[WORD_W-2:0], w_raw};
         end
      end
   end

   // output word register and valid flag; an abort wipes the word even mid-handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (w_abort) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (r_state == S_CHECK && !w_stuck) begin
         r_data  <= r_shift;
         r_valid <= 1'b1;
      end else if (w_hs) begin
         r_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_ro_trng_ctrl.sv
// tb_ro_trng_ctrl: vector table, scoreboard and corner-case sequences for ro_trng_ctrl
module tb_ro_trng_ctrl;
   localparam int NR     = 2;
   localparam int WU     = 4;
   localparam int DIV    = 2;
   localparam int WW     = 8;
   localparam int FIRST  = 1 + WU + WW * DIV + 1;
   localparam int PERIOD = WW * DIV + 1;

   typedef struct {int cyc; logic [WW-1:0] data;} exp_t;
   typedef struct {logic start; logic stop; logic busy; logic [NR-1:0] ro_en;} vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          rnd_ready = 1'b0;
   logic [NR-1:0] ro_in = '0;
   logic [NR-1:0] ro_en;
   logic [WW-1:0] rnd_data;
   logic          rnd_valid;
   logic          busy;
   logic          stuck_err;
   logic          rb = 1'b0;
   logic          pv = 1'b0;
   logic [WW-1:0] pd = '0;
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            t0 = 0;
   int            mode = 0;
   int            hs_cnt = 0;
   exp_t          sb[$];
   vec_t          vecs[10];

   ro_trng_ctrl #(.NUM_RO(NR), .WARMUP_CYCLES(WU), .SAMPLE_DIV(DIV), .WORD_W(WW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ro_en(ro_en), .ro_in(ro_in),
      .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .busy(busy),
      .stuck_err(stuck_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // intended raw bit at absolute cycle c (relative to the last start)
   function automatic logic g(int c);
      return ((c - t0) % 4) >= 2;
   endfunction

   // word assembled from a sampling window whose first divider cycle is s
   function automatic logic [WW-1:0] word_at(int s);
      logic [WW-1:0] w = '0;
      for (int j = 0; j < WW; j++) w = {w[WW-2:0], g(s + j * DIV + DIV - 1)};
      return w;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at rel cycle %0d: got %0d (0x%0h), expected %0d (0x%0h)", name, cyc - t0, act, act, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go();
      t0 = cyc;
      start = 1'b1;
      if (mode == 0) sb.push_back('{t0 + FIRST, word_at(t0 + 1 + WU)});
      tick();
      start = 1'b0;
   endtask

   task automatic halt();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      sb.delete();
   endtask

   task automatic wait_rel(input int r);
      while (cyc - t0 < r) tick();
   endtask

   task automatic wait_valid(input int lim, output int at);
      at = -1;
      for (int i = 0; i < lim && !rnd_valid; i++) tick();
      chk("valid_timeout", 32'(rnd_valid), 1);
      if (rnd_valid) at = cyc - t0;
   endtask

   // oscillator stimulus: drive two cycles ahead of the bit it should produce
   always @(posedge clk) begin
      #1;
      rb = 1'($urandom_range(0, 1));
      ro_in = (mode == 0) ? {rb, rb ^ g(cyc + 2)} : (mode == 1) ? 2'b00 : 2'b01;
   end

   // scoreboard monitor
   always @(posedge clk) begin
      #2;
      if (rnd_valid && !pv) begin
         if (sb.size() == 0) chk("unexpected_valid", 32'(rnd_valid), 0);
         else begin
            chk("valid_cycle", cyc - t0, sb[0].cyc - t0);
            chk("word_data", 32'(rnd_data), 32'(sb[0].data));
         end
      end
      if (rnd_valid && pv) chk("data_stable", 32'(rnd_data), 32'(pd));
      if (rnd_valid && rnd_ready && !stop && rst_n) begin
         if (sb.size() > 0) void'(sb.pop_front());
         hs_cnt++;
         sb.push_back('{cyc + PERIOD, word_at(cyc)});
      end
      pv = rnd_valid;
      pd = rnd_data;
   end

   initial begin
      int at;
      vecs[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 2'b00};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 2'b00};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 2'b11};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 2'b11};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 2'b00};
      vecs[6] = '{1'b0, 1'b0, 1'b0, 2'b00};
      vecs[7] = '{1'b1, 1'b0, 1'b1, 2'b11};
      vecs[8] = '{1'b1, 1'b0, 1'b1, 2'b11};
      vecs[9] = '{1'b0, 1'b1, 1'b0, 2'b00};
      tick();
      tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ro_en", 32'(ro_en), 0);
      chk("rst_valid", 32'(rnd_valid), 0);
      chk("rst_data", 32'(rnd_data), 0);
      chk("rst_stuck", 32'(stuck_err), 0);
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         start = vecs[i].start;
         stop = vecs[i].stop;
         tick();
         start = 1'b0;
         stop = 1'b0;
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
         chk($sformatf("vec%0d_ro_en", i), 32'(ro_en), 32'(vecs[i].ro_en));
         chk($sformatf("vec%0d_valid", i), 32'(rnd_valid), 0);
      end
      tick();
      // continuous ready: alternating bits, 17-cycle word cadence, stop during HOLD with ready
      rnd_ready = 1'b1;
      hs_cnt = 0;
      go();
      chk("t2_ro_en_c1", 32'(ro_en), 2'b11);
      chk("t2_busy_c1", 32'(busy), 1);
      wait_rel(FIRST - 1);
      chk("t2_valid_early", 32'(rnd_valid), 0);
      tick();
      chk("t2_valid_c22", 32'(rnd_valid), 1);
      chk("t2_data_c22", 32'(rnd_data), 8'hAA);
      tick();
      chk("t2_valid_one_cycle", 32'(rnd_valid), 0);
      wait_rel(FIRST + PERIOD - 1);
      chk("t2_valid_c38", 32'(rnd_valid), 0);
      tick();
      chk("t2_valid_c39", 32'(rnd_valid), 1);
      wait_rel(FIRST + 2 * PERIOD);
      chk("t2_valid_c56", 32'(rnd_valid), 1);
      halt();
      chk("t5_stop_busy", 32'(busy), 0);
      chk("t5_stop_ro_en", 32'(ro_en), 0);
      chk("t5_stop_valid", 32'(rnd_valid), 0);
      chk("t5_stop_data", 32'(rnd_data), 0);
      chk("t2_handshakes", 32'(hs_cnt), 2);
      // backpressure: word held for 10 cycles, next word 17 cycles after the handshake
      rnd_ready = 1'b0;
      tick();
      go();
      wait_valid(40, at);
      chk("t3_first_cycle", 32'(at), FIRST);
      for (int i = 0; i < 10; i++) begin
         chk("t3_hold_valid", 32'(rnd_valid), 1);
         chk("t3_hold_data", 32'(rnd_data), 8'hAA);
         tick();
      end
      rnd_ready = 1'b1;
      tick();
      rnd_ready = 1'b0;
      chk("t3_valid_after_hs", 32'(rnd_valid), 0);
      chk("t3_data_kept", 32'(rnd_data), 8'hAA);
      wait_valid(40, at);
      chk("t3_next_cycle", 32'(at), FIRST + 10 + PERIOD);
      halt();
      chk("t3_stop_data", 32'(rnd_data), 0);
      // stuck words: all zeros (ro_in=00) then all ones (ro_in=01)
      for (int m = 1; m <= 2; m++) begin
         mode = m;
         rnd_ready = 1'b1;
         repeat (3) tick();
         go();
         for (int r = 1; r <= 60; r++) begin
            chk("t4_stuck", 32'(stuck_err), 32'(r >= FIRST - 1 && (r - (FIRST - 1)) % PERIOD == 0));
            chk("t4_busy", 32'(busy), 1);
            chk("t4_valid", 32'(rnd_valid), 0);
            tick();
         end
         halt();
      end
      // start while sampling is ignored
      mode = 0;
      repeat (3) tick();
      go();
      wait_rel(10);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_rel(FIRST - 1);
      chk("t6_valid_c21", 32'(rnd_valid), 0);
      tick();
      chk("t6_valid_c22", 32'(rnd_valid), 1);
      chk("t6_data_c22", 32'(rnd_data), 8'hAA);
      halt();
      // asynchronous reset in the middle of HOLD
      rnd_ready = 1'b0;
      tick();
      go();
      wait_rel(FIRST + 3);
      chk("t1_hold_valid", 32'(rnd_valid), 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t1_async_busy", 32'(busy), 0);
      chk("t1_async_ro_en", 32'(ro_en), 0);
      chk("t1_async_valid", 32'(rnd_valid), 0);
      chk("t1_async_data", 32'(rnd_data), 0);
      chk("t1_async_stuck", 32'(stuck_err), 0);
      sb.delete();
      tick();
      rst_n = 1'b1;
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
